// File: rtl/cavlc_total_zeros_encoder_pkg.sv
// Shared types and constants for the CAVLC total_zeros encoder: FSM states and
// the {len, code} LUT record.
package cavlc_total_zeros_encoder_pkg;

    localparam int TZE_OUT_W  = 16;
    localparam int TZE_ACC_W  = 32;
    localparam int TZE_CODE_W = 9;
    localparam int TZE_LEN_W  = 4;

    typedef enum logic [1:0] {
        TZE_RUN,
        TZE_FLUSH,
        TZE_DONE
    } tze_state_e;

    // len == 0 marks a combination with no codeword
    typedef struct packed {
        logic [TZE_LEN_W-1:0]  len;
        logic [TZE_CODE_W-1:0] code;
    } vlc_t;

endpackage

// File: rtl/cavlc_total_zeros_encoder_lut.sv
// total_zeros VLC table: Tables 9-7/9-8 (4x4) and 9-9a (chroma DC 2x2).
// Purely combinational; codes are right-aligned, len 1..9, len 0 = illegal.
module total_zeros_vlc_lut
    import cavlc_total_zeros_encoder_pkg::*;
(
    input  logic [3:0] tc,
    input  logic [3:0] tz,
    input  logic       chroma_dc,
    output logic [8:0] code,
    output logic [3:0] len,
    output logic       illegal
);

    vlc_t e;

    // Selector is {chroma_dc, tc, tz}; anything not listed is out of range.
    always_comb begin
        e = '0;
        case ({chroma_dc, tc, tz})
            9'h010: e = {4'd1, 9'd1};  9'h011: e = {4'd3, 9'd3};  9'h012: e = {4'd3, 9'd2};  9'h013: e = {4'd4, 9'd3};
            9'h014: e = {4'd4, 9'd2};  9'h015: e = {4'd5, 9'd3};  9'h016: e = {4'd5, 9'd2};  9'h017: e = {4'd6, 9'd3};
            9'h018: e = {4'd6, 9'd2};  9'h019: e = {4'd7, 9'd3};  9'h01A: e = {4'd7, 9'd2};  9'h01B: e = {4'd8, 9'd3};
            9'h01C: e = {4'd8, 9'd2};  9'h01D: e = {4'd9, 9'd3};  9'h01E: e = {4'd9, 9'd2};  9'h01F: e = {4'd9, 9'd1};

            9'h020: e = {4'd3, 9'd7};  9'h021: e = {4'd3, 9'd6};  9'h022: e = {4'd3, 9'd5};  9'h023: e = {4'd3, 9'd4};
            9'h024: e = {4'd3, 9'd3};  9'h025: e = {4'd4, 9'd5};  9'h026: e = {4'd4, 9'd4};  9'h027: e = {4'd4, 9'd3};
            9'h028: e = {4'd4, 9'd2};  9'h029: e = {4'd5, 9'd3};  9'h02A: e = {4'd5, 9'd2};  9'h02B: e = {4'd6, 9'd3};
            9'h02C: e = {4'd6, 9'd2};  9'h02D: e = {4'd6, 9'd1};  9'h02E: e = {4'd6, 9'd0};

            9'h030: e = {4'd4, 9'd5};  9'h031: e = {4'd3, 9'd7};  9'h032: e = {4'd3, 9'd6};  9'h033: e = {4'd3, 9'd5};
            9'h034: e = {4'd4, 9'd4};  9'h035: e = {4'd4, 9'd3};  9'h036: e = {4'd3, 9'd4};  9'h037: e = {4'd3, 9'd3};
            9'h038: e = {4'd4, 9'd2};  9'h039: e = {4'd5, 9'd3};  9'h03A: e = {4'd5, 9'd2};  9'h03B: e = {4'd6, 9'd1};
            9'h03C: e = {4'd5, 9'd1};  9'h03D: e = {4'd6, 9'd0};

            9'h040: e = {4'd5, 9'd3};  9'h041: e = {4'd3, 9'd7};  9'h042: e = {4'd4, 9'd5};  9'h043: e = {4'd4, 9'd4};
            9'h044: e = {4'd3, 9'd6};  9'h045: e = {4'd3, 9'd5};  9'h046: e = {4'd3, 9'd4};  9'h047: e = {4'd4, 9'd3};
            9'h048: e = {4'd3, 9'd3};  9'h049: e = {4'd4, 9'd2};  9'h04A: e = {4'd5, 9'd2};  9'h04B: e = {4'd5, 9'd1};
            9'h04C: e = {4'd5, 9'd0};

            9'h050: e = {4'd4, 9'd5};  9'h051: e = {4'd4, 9'd4};  9'h052: e = {4'd4, 9'd3};  9'h053: e = {4'd3, 9'd7};
            9'h054: e = {4'd3, 9'd6};  9'h055: e = {4'd3, 9'd5};  9'h056: e = {4'd3, 9'd4};  9'h057: e = {4'd3, 9'd3};
            9'h058: e = {4'd4, 9'd2};  9'h059: e = {4'd5, 9'd1};  9'h05A: e = {4'd4, 9'd1};  9'h05B: e = {4'd5, 9'd0};

            9'h060: e = {4'd6, 9'd1};  9'h061: e = {4'd5, 9'd1};  9'h062: e = {4'd3, 9'd7};  9'h063: e = {4'd3, 9'd6};
            9'h064: e = {4'd3, 9'd5};  9'h065: e = {4'd3, 9'd4};  9'h066: e = {4'd3, 9'd3};  9'h067: e = {4'd3, 9'd2};
            9'h068: e = {4'd4, 9'd1};  9'h069: e = {4'd3, 9'd1};  9'h06A: e = {4'd6, 9'd0};

            9'h070: e = {4'd6, 9'd1};  9'h071: e = {4'd5, 9'd1};  9'h072: e = {4'd3, 9'd5};  9'h073: e = {4'd3, 9'd4};
            9'h074: e = {4'd3, 9'd3};  9'h075: e = {4'd2, 9'd3};  9'h076: e = {4'd3, 9'd2};  9'h077: e = {4'd4, 9'd1};
            9'h078: e = {4'd3, 9'd1};  9'h079: e = {4'd6, 9'd0};

            9'h080: e = {4'd6, 9'd1};  9'h081: e = {4'd4, 9'd1};  9'h082: e = {4'd5, 9'd1};  9'h083: e = {4'd3, 9'd3};
            9'h084: e = {4'd2, 9'd3};  9'h085: e = {4'd2, 9'd2};  9'h086: e = {4'd3, 9'd2};  9'h087: e = {4'd3, 9'd1};
            9'h088: e = {4'd6, 9'd0};

            9'h090: e = {4'd6, 9'd1};  9'h091: e = {4'd6, 9'd0};  9'h092: e = {4'd4, 9'd1};  9'h093: e = {4'd2, 9'd3};
            9'h094: e = {4'd2, 9'd2};  9'h095: e = {4'd3, 9'd1};  9'h096: e = {4'd2, 9'd1};  9'h097: e = {4'd5, 9'd1};

            9'h0A0: e = {4'd5, 9'd1};  9'h0A1: e = {4'd5, 9'd0};  9'h0A2: e = {4'd3, 9'd1};  9'h0A3: e = {4'd2, 9'd3};
            9'h0A4: e = {4'd2, 9'd2};  9'h0A5: e = {4'd2, 9'd1};  9'h0A6: e = {4'd4, 9'd1};

            9'h0B0: e = {4'd4, 9'd0};  9'h0B1: e = {4'd4, 9'd1};  9'h0B2: e = {4'd3, 9'd1};  9'h0B3: e = {4'd3, 9'd2};
            9'h0B4: e = {4'd1, 9'd1};  9'h0B5: e = {4'd3, 9'd3};

            9'h0C0: e = {4'd4, 9'd0};  9'h0C1: e = {4'd4, 9'd1};  9'h0C2: e = {4'd2, 9'd1};  9'h0C3: e = {4'd1, 9'd1};
            9'h0C4: e = {4'd3, 9'd1};

            9'h0D0: e = {4'd3, 9'd0};  9'h0D1: e = {4'd3, 9'd1};  9'h0D2: e = {4'd1, 9'd1};  9'h0D3: e = {4'd2, 9'd1};
            9'h0E0: e = {4'd2, 9'd0};  9'h0E1: e = {4'd2, 9'd1};  9'h0E2: e = {4'd1, 9'd1};
            9'h0F0: e = {4'd1, 9'd0};  9'h0F1: e = {4'd1, 9'd1};

            9'h110: e = {4'd1, 9'd1};  9'h111: e = {4'd2, 9'd1};  9'h112: e = {4'd3, 9'd1};  9'h113: e = {4'd3, 9'd0};
            9'h120: e = {4'd1, 9'd1};  9'h121: e = {4'd2, 9'd1};  9'h122: e = {4'd2, 9'd0};
            9'h130: e = {4'd1, 9'd1};  9'h131: e = {4'd1, 9'd0};
            default: e = '0;
        endcase
    end

    assign code    = e.code;
    assign len     = e.len;
    assign illegal = (e.len == '0);

endmodule

// File: rtl/cavlc_total_zeros_encoder.sv
// CAVLC total_zeros encoder: LUT-mapped codewords packed MSB-first into an
// accumulator and drained as 16-bit words; flush pads the tail to a word.
module cavlc_total_zeros_encoder
    import cavlc_total_zeros_encoder_pkg::*;
#(
    parameter int OUT_W = TZE_OUT_W,
    parameter int ACC_W = TZE_ACC_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [3:0]       sym_total_coeff,
    input  logic [3:0]       sym_total_zeros,
    input  logic             sym_chroma_dc,
    input  logic             flush_req,
    output logic             flush_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_word,
    output logic             sym_err,
    output logic [4:0]       fill_level
);

    localparam int FILL_W = $clog2(ACC_W + 1);

    tze_state_e              state, state_d;
    logic [ACC_W-1:0]        acc, acc_d;
    logic [FILL_W-1:0]       fill, fill_d, base, shamt;
    logic [TZE_CODE_W-1:0]   code;
    logic [TZE_LEN_W-1:0]    len;
    logic                    illegal, sym_fire, push, pop, err_q;

    total_zeros_vlc_lut u_lut (
        .tc        (sym_total_coeff),
        .tz        (sym_total_zeros),
        .chroma_dc (sym_chroma_dc),
        .code      (code),
        .len       (len),
        .illegal   (illegal)
    );

    // Headroom for the longest (9-bit) codeword keeps the accumulator from overflowing.
    assign sym_ready  = (state == TZE_RUN) && (fill <= FILL_W'(ACC_W - TZE_CODE_W));
    assign out_valid  = (fill >= FILL_W'(OUT_W));
    assign out_word   = acc[ACC_W-1 -: OUT_W];
    assign flush_done = (state == TZE_DONE);
    assign sym_err    = err_q;
    // fill can momentarily reach ACC_W; the 5-bit view saturates rather than wraps
    assign fill_level = (fill > FILL_W'(31)) ? 5'd31 : fill[4:0];

    assign sym_fire = sym_valid & sym_ready;
    assign push     = sym_fire & ~illegal;
    assign pop      = out_valid & out_ready;

    // Pop shifts first, so a same-cycle push lands relative to the post-pop fill.
    always_comb begin
        state_d = state;
        base    = pop ? fill - FILL_W'(OUT_W) : fill;
        acc_d   = pop ? (acc << OUT_W) : acc;
        shamt   = FILL_W'(ACC_W) - base - FILL_W'(len);
        fill_d  = base;
        if (push) begin
            acc_d  = acc_d | (ACC_W'(code) << shamt);
            fill_d = base + FILL_W'(len);
        end
        case (state)
            TZE_RUN: begin
                if (flush_req) state_d = TZE_FLUSH;
            end
            TZE_FLUSH: begin
                // Bits below fill are already zero, so padding is just a fill bump.
                if (fill == '0)                    state_d = TZE_DONE;
                else if (fill < FILL_W'(OUT_W))    fill_d  = FILL_W'(OUT_W);
            end
            TZE_DONE: state_d = TZE_RUN;
            default:  state_d = TZE_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= TZE_RUN;
            acc   <= '0;
            fill  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            fill  <= fill_d;
            err_q <= sym_fire & illegal;
        end
    end

endmodule

// File: tb/tb_cavlc_total_zeros_encoder.sv
// Directed bench for cavlc_total_zeros_encoder: table of single-symbol encodes
// checked through a flush, plus hand sequences for backpressure, reset and errors.
module tb_cavlc_total_zeros_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sym_valid, sym_ready;
    logic [3:0]  sym_total_coeff, sym_total_zeros;
    logic        sym_chroma_dc;
    logic        flush_req, flush_done;
    logic        out_valid, out_ready;
    logic [15:0] out_word;
    logic        sym_err;
    logic [4:0]  fill_level;

    int n_tests = 0;
    int n_fail  = 0;
    int wcnt    = 0;

    cavlc_total_zeros_encoder dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sym_valid       (sym_valid),
        .sym_ready       (sym_ready),
        .sym_total_coeff (sym_total_coeff),
        .sym_total_zeros (sym_total_zeros),
        .sym_chroma_dc   (sym_chroma_dc),
        .flush_req       (flush_req),
        .flush_done      (flush_done),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_word        (out_word),
        .sym_err         (sym_err),
        .fill_level      (fill_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (reset_n && out_valid && out_ready) wcnt++;

    typedef struct {
        logic [3:0]  tc;
        logic [3:0]  tz;
        logic        cd;
        logic        ill;
        int          len;
        logic [15:0] word;
    } vec_t;

    vec_t vecs [0:27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [3:0] tc, input logic [3:0] tz, input logic cd);
        int i;
        sym_total_coeff = tc;
        sym_total_zeros = tz;
        sym_chroma_dc   = cd;
        sym_valid       = 1'b1;
        for (i = 0; i < 50 && !sym_ready; i++) @(negedge clk);
        if (!sym_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: sym_ready stayed 0 for tc=%0d tz=%0d", tc, tz);
        end
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    task automatic wait_word(input string name, input logic [15:0] exp);
        int i;
        for (i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        if (!out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: out_valid never rose, expected word %0h", name, exp);
        end else begin
            chk(name, out_word, exp);
        end
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 20 && !flush_done; i++) @(negedge clk);
        chk(name, flush_done, 1);
        @(negedge clk);
    endtask

    initial begin
        int w0;
        vecs[0]  = '{4'd1,  4'd0,  1'b0, 1'b0, 1, 16'h8000};
        vecs[1]  = '{4'd1,  4'd15, 1'b0, 1'b0, 9, 16'h0080};
        vecs[2]  = '{4'd2,  4'd0,  1'b0, 1'b0, 3, 16'hE000};
        vecs[3]  = '{4'd2,  4'd14, 1'b0, 1'b0, 6, 16'h0000};
        vecs[4]  = '{4'd3,  4'd0,  1'b0, 1'b0, 4, 16'h5000};
        vecs[5]  = '{4'd3,  4'd12, 1'b0, 1'b0, 5, 16'h0800};
        vecs[6]  = '{4'd4,  4'd0,  1'b0, 1'b0, 5, 16'h1800};
        vecs[7]  = '{4'd5,  4'd9,  1'b0, 1'b0, 5, 16'h0800};
        vecs[8]  = '{4'd6,  4'd9,  1'b0, 1'b0, 3, 16'h2000};
        vecs[9]  = '{4'd7,  4'd5,  1'b0, 1'b0, 2, 16'hC000};
        vecs[10] = '{4'd8,  4'd2,  1'b0, 1'b0, 5, 16'h0800};
        vecs[11] = '{4'd9,  4'd6,  1'b0, 1'b0, 2, 16'h4000};
        vecs[12] = '{4'd10, 4'd1,  1'b0, 1'b0, 5, 16'h0000};
        vecs[13] = '{4'd11, 4'd4,  1'b0, 1'b0, 1, 16'h8000};
        vecs[14] = '{4'd12, 4'd4,  1'b0, 1'b0, 3, 16'h2000};
        vecs[15] = '{4'd13, 4'd3,  1'b0, 1'b0, 2, 16'h4000};
        vecs[16] = '{4'd14, 4'd2,  1'b0, 1'b0, 1, 16'h8000};
        vecs[17] = '{4'd15, 4'd0,  1'b0, 1'b0, 1, 16'h0000};
        vecs[18] = '{4'd15, 4'd1,  1'b0, 1'b0, 1, 16'h8000};
        vecs[19] = '{4'd1,  4'd3,  1'b1, 1'b0, 3, 16'h0000};
        vecs[20] = '{4'd2,  4'd1,  1'b1, 1'b0, 2, 16'h4000};
        vecs[21] = '{4'd3,  4'd1,  1'b1, 1'b0, 1, 16'h0000};
        vecs[22] = '{4'd0,  4'd0,  1'b0, 1'b1, 0, 16'h0000};
        vecs[23] = '{4'd4,  4'd13, 1'b0, 1'b1, 0, 16'h0000};
        vecs[24] = '{4'd15, 4'd2,  1'b0, 1'b1, 0, 16'h0000};
        vecs[25] = '{4'd4,  4'd0,  1'b1, 1'b1, 0, 16'h0000};
        vecs[26] = '{4'd2,  4'd3,  1'b1, 1'b1, 0, 16'h0000};
        vecs[27] = '{4'd1,  4'd8,  1'b0, 1'b0, 6, 16'h0800};

        reset_n = 1'b0; sym_valid = 1'b0; flush_req = 1'b0; out_ready = 1'b1;
        sym_total_coeff = '0; sym_total_zeros = '0; sym_chroma_dc = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_fill", fill_level, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sym_ready", sym_ready, 1);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_sym_err", sym_err, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single-symbol vectors: fill must equal len, flushed word shows the code bits.
        for (int v = 0; v < 28; v++) begin
            push(vecs[v].tc, vecs[v].tz, vecs[v].cd);
            chk($sformatf("vec%0d_fill", v), fill_level, vecs[v].len);
            chk($sformatf("vec%0d_err", v), sym_err, vecs[v].ill);
            if (!vecs[v].ill) begin
                do_flush();
                wait_word($sformatf("vec%0d_word", v), vecs[v].word);
                wait_done($sformatf("vec%0d_done", v));
            end else begin
                @(negedge clk);
                chk($sformatf("vec%0d_err_pulse", v), sym_err, 0);
            end
        end

        // Flush of an empty accumulator: flush_done two edges later, one cycle wide.
        repeat (2) @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        chk("empty_flush_n1_done", flush_done, 0);
        chk("empty_flush_n1_ready", sym_ready, 0);
        @(negedge clk);
        chk("empty_flush_n2_done", flush_done, 1);
        @(negedge clk);
        chk("empty_flush_n3_done", flush_done, 0);
        chk("empty_flush_n3_ready", sym_ready, 1);

        // Reset mid-stream discards buffered bits.
        for (int i = 0; i < 12; i++) push(4'd1, 4'd0, 1'b0);
        chk("mid_fill12", fill_level, 12);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_fill", fill_level, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", sym_ready, 1);
        chk("mid_rst_done", flush_done, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Sixteen one-bit codes make exactly one all-ones word.
        w0 = wcnt;
        for (int i = 0; i < 16; i++) push(4'd1, 4'd0, 1'b0);
        chk("ones_valid", out_valid, 1);
        chk("ones_word", out_word, 16'hFFFF);
        @(negedge clk);
        chk("ones_fill", fill_level, 0);
        chk("ones_valid_after", out_valid, 0);
        chk("ones_wcnt", wcnt - w0, 1);

        // Two 9-bit codes straddle a word; the tail is padded by flush.
        push(4'd1, 4'd15, 1'b0);
        push(4'd1, 4'd15, 1'b0);
        chk("two9_word", out_word, 16'h0080);
        chk("two9_valid", out_valid, 1);
        do_flush();
        chk("two9_flush_ready", sym_ready, 0);
        wait_word("two9_tail", 16'h4000);
        wait_done("two9_done");

        // Chroma DC code followed by a 4x4 code.
        push(4'd1, 4'd3, 1'b1);
        push(4'd1, 4'd0, 1'b0);
        chk("chroma_fill", fill_level, 4);
        do_flush();
        wait_word("chroma_word", 16'h1000);
        wait_done("chroma_done");

        // Backpressure: sym_ready drops at fill 27, word held stable until popped.
        out_ready = 1'b0;
        w0 = wcnt;
        push(4'd1, 4'd15, 1'b0);
        push(4'd1, 4'd15, 1'b0);
        chk("bp_ready18", sym_ready, 1);
        push(4'd1, 4'd15, 1'b0);
        chk("bp_fill27", fill_level, 27);
        chk("bp_ready27", sym_ready, 0);
        chk("bp_word", out_word, 16'h0080);
        @(negedge clk);
        chk("bp_word_hold", out_word, 16'h0080);
        chk("bp_fill_hold", fill_level, 27);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_fill11", fill_level, 11);
        chk("bp_ready11", sym_ready, 1);
        chk("bp_wcnt", wcnt - w0, 1);
        do_flush();
        wait_word("bp_tail", 16'h4020);
        wait_done("bp_done");

        // Illegal symbols are consumed without touching fill.
        push(4'd1, 4'd0, 1'b0);
        push(4'd0, 4'd0, 1'b0);
        chk("ill_a_err", sym_err, 1);
        chk("ill_a_fill", fill_level, 1);
        @(negedge clk);
        chk("ill_a_pulse", sym_err, 0);
        push(4'd3, 4'd2, 1'b1);
        chk("ill_b_err", sym_err, 1);
        chk("ill_b_fill", fill_level, 1);
        do_flush();
        wait_word("ill_word", 16'h8000);
        wait_done("ill_done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
